// File: rtl/grill_drive_ctrl.sv
// Grill motor direction controller: open/close requests -> 4-bit direction word, with reversal
// dead-time, sticky FAULT and optional stall watchdog (enable with GRILL_STALL_DETECT_EN).
module grill_drive_ctrl #(
    parameter int P_DEADTIME     = 16,
    parameter int P_STALL_CYCLES = 50000,
    parameter int P_STALL_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_open_cmd,
    input  logic       i_close_cmd,
    input  logic       i_fault_clr,
    input  logic [1:0] i_pos,
    input  logic       i_sensor,
    output logic [3:0] o_dir,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_OPENING = 3'd1;
    localparam logic [2:0] S_CLOSING = 3'd2;
    localparam logic [2:0] S_BRAKE   = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam logic [1:0] PEND_DONE  = 2'd0;
    localparam logic [1:0] PEND_OPEN  = 2'd1;
    localparam logic [1:0] PEND_CLOSE = 2'd2;

    localparam logic [1:0] POS_CLOSED = 2'b00;
    localparam logic [1:0] POS_OPEN   = 2'b01;
    localparam logic [1:0] POS_INV    = 2'b11;

    localparam int DT_W = (P_DEADTIME > 1) ? $clog2(P_DEADTIME) : 1;
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(P_DEADTIME - 1);

    logic [2:0]      state_q, state_d;
    logic [1:0]      pend_q, pend_d, nxt_pend;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic [3:0]      dir_q;
    logic            busy_q, done_q, done_d, fault_q;
    logic            open_v, close_v, moving_q, moving_d, stall_fault;

    // Simultaneous open and close requests cancel each other everywhere.
    assign open_v   = i_open_cmd & ~i_close_cmd;
    assign close_v  = i_close_cmd & ~i_open_cmd;
    assign moving_q = (state_q == S_OPENING) || (state_q == S_CLOSING);
    assign moving_d = (state_d == S_OPENING) || (state_d == S_CLOSING);

`ifdef GRILL_STALL_DETECT_EN
    localparam logic [P_STALL_W-1:0] STALL_LIM = P_STALL_W'(P_STALL_CYCLES);

    logic [2:0]           sync_q;
    logic                 sens_rise;
    logic [P_STALL_W-1:0] stall_q, stall_d;

    // sync_q[1:0] is the synchroniser, sync_q[2] the edge-detect history.
    assign sens_rise   = sync_q[1] & ~sync_q[2];
    assign stall_fault = moving_q && (stall_q >= STALL_LIM);

    always_comb begin
        stall_d = '0;
        if (moving_d && moving_q && !sens_rise) begin
            stall_d = (stall_q >= STALL_LIM) ? stall_q : stall_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            stall_q <= '0;
        end else begin
            sync_q  <= {sync_q[1:0], i_sensor};
            stall_q <= stall_d;
        end
    end
`else
    localparam int unused_stall_cfg = P_STALL_CYCLES + P_STALL_W;
    logic unused_sensor;
    assign unused_sensor = i_sensor;
    assign stall_fault   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        nxt_pend = pend_q;
        if ((i_pos == POS_INV) || stall_fault) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (open_v) begin
                        if (i_pos == POS_OPEN) done_d = 1'b1;
                        else                   state_d = S_OPENING;
                    end else if (close_v) begin
                        if (i_pos == POS_CLOSED) done_d = 1'b1;
                        else                     state_d = S_CLOSING;
                    end
                end
                S_OPENING: begin
                    if (i_pos == POS_OPEN) begin
                        state_d = S_BRAKE; pend_d = PEND_DONE;  cnt_d = '0;
                    end else if (close_v) begin
                        state_d = S_BRAKE; pend_d = PEND_CLOSE; cnt_d = '0;
                    end
                end
                S_CLOSING: begin
                    if (i_pos == POS_CLOSED) begin
                        state_d = S_BRAKE; pend_d = PEND_DONE; cnt_d = '0;
                    end else if (open_v) begin
                        state_d = S_BRAKE; pend_d = PEND_OPEN; cnt_d = '0;
                    end
                end
                S_BRAKE: begin
                    if (open_v)       nxt_pend = PEND_OPEN;
                    else if (close_v) nxt_pend = PEND_CLOSE;
                    pend_d = nxt_pend;
                    if (cnt_q == DT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        // A pending move whose end is already held completes immediately.
                        if (nxt_pend == PEND_OPEN && i_pos != POS_OPEN)          state_d = S_OPENING;
                        else if (nxt_pend == PEND_CLOSE && i_pos != POS_CLOSED) state_d = S_CLOSING;
                        else                                                     done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (i_fault_clr) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pend_q  <= PEND_DONE;
            cnt_q   <= '0;
            dir_q   <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            dir_q   <= {2'b00, state_d == S_CLOSING, state_d == S_OPENING};
            busy_q  <= moving_d || (state_d == S_BRAKE);
            done_q  <= done_d;
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign o_dir   = dir_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_fault = fault_q;
endmodule

// File: tb/tb_grill_drive_ctrl.sv
// Directed vector table plus stall-watchdog sequence for grill_drive_ctrl.
module tb_grill_drive_ctrl;
    logic       clk = 1'b0;
    logic       rst, open_cmd, close_cmd, fault_clr, sensor;
    logic [1:0] pos;
    logic [3:0] dir;
    logic       busy, done, fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, open, close, clr;
        logic [1:0] pos;
        logic [3:0] dir;
        logic       busy, done, fault;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    grill_drive_ctrl #(.P_DEADTIME(16), .P_STALL_CYCLES(100), .P_STALL_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_open_cmd(open_cmd), .i_close_cmd(close_cmd),
        .i_fault_clr(fault_clr), .i_pos(pos), .i_sensor(sensor),
        .o_dir(dir), .o_busy(busy), .o_done(done), .o_fault(fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic o, input logic c, input logic cl,
                       input logic [1:0] p, input logic [3:0] d, input logic b,
                       input logic dn, input logic f);
        vec_t v;
        v.rst = r; v.open = o; v.close = c; v.clr = cl; v.pos = p;
        v.dir = d; v.busy = b; v.done = dn; v.fault = f;
        vecs.push_back(v);
    endtask

    // Direction-word safety: never 11, and a reversal needs at least 16 idle cycles.
    logic [1:0] last_nz = 2'b00;
    int         zero_run = 0;
    always @(negedge clk) begin
        if (!busy) begin
            last_nz  = 2'b00;
            zero_run = 0;
        end
        if (dir[1:0] == 2'b11) begin
            checks++; errors++;
            $display("FAIL dir_both: got %b", dir);
        end
        if (dir[1:0] == 2'b00) begin
            zero_run++;
        end else begin
            if (last_nz != 2'b00 && last_nz != dir[1:0]) begin
                checks++;
                if (zero_run < 16) begin
                    errors++;
                    $display("FAIL deadtime: got %0d zero cycles expected >=16", zero_run);
                end
            end
            last_nz  = dir[1:0];
            zero_run = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int since;
        bit seen;
        rst = 1'b1; open_cmd = 1'b0; close_cmd = 1'b0; fault_clr = 1'b0;
        pos = 2'b00; sensor = 1'b0;

        //   rst o c clr pos    dir   b d f
        add(1, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
        add(0, 1, 0, 0, 2'b00, 4'h1, 1, 0, 0);
        add(0, 0, 0, 0, 2'b10, 4'h1, 1, 0, 0);
        add(0, 1, 1, 0, 2'b10, 4'h1, 1, 0, 0);
        add(0, 0, 0, 0, 2'b01, 4'h0, 1, 0, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 2'b01, 4'h0, 1, 0, 0);
        add(0, 0, 0, 0, 2'b01, 4'h0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 4'h0, 0, 0, 0);
        // target already held
        add(0, 1, 0, 0, 2'b01, 4'h0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 4'h0, 0, 0, 0);
        add(0, 1, 1, 0, 2'b10, 4'h0, 0, 0, 0);
        // closing then invalid position
        add(0, 0, 1, 0, 2'b10, 4'h2, 1, 0, 0);
        add(0, 0, 0, 0, 2'b11, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 2'b10, 4'h0, 0, 0, 1);
        add(0, 0, 0, 1, 2'b11, 4'h0, 0, 0, 1);
        add(0, 0, 0, 1, 2'b10, 4'h0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b10, 4'h0, 0, 0, 0);
        // reversal open -> close through dead-time
        add(0, 1, 0, 0, 2'b10, 4'h1, 1, 0, 0);
        add(0, 0, 1, 0, 2'b10, 4'h0, 1, 0, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 2'b10, 4'h0, 1, 0, 0);
        add(0, 0, 0, 0, 2'b10, 4'h2, 1, 0, 0);
        add(1, 0, 0, 0, 2'b10, 4'h0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b10, 4'h0, 0, 0, 0);
        // pending overwritten during brake
        add(0, 1, 0, 0, 2'b10, 4'h1, 1, 0, 0);
        add(0, 0, 1, 0, 2'b10, 4'h0, 1, 0, 0);
        add(0, 1, 0, 0, 2'b10, 4'h0, 1, 0, 0);
        for (int i = 0; i < 14; i++) add(0, 0, 0, 0, 2'b10, 4'h0, 1, 0, 0);
        add(0, 0, 0, 0, 2'b10, 4'h1, 1, 0, 0);
        add(1, 0, 0, 0, 2'b10, 4'h0, 0, 0, 0);
        // pending close whose end is reached during brake
        add(0, 1, 0, 0, 2'b10, 4'h1, 1, 0, 0);
        add(0, 0, 1, 0, 2'b10, 4'h0, 1, 0, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 0, 0, 2'b00, 4'h0, 1, 0, 0);
        add(0, 0, 0, 0, 2'b00, 4'h0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
        // fault has priority over a command
        add(0, 1, 0, 0, 2'b11, 4'h0, 0, 0, 1);
        add(0, 0, 0, 1, 2'b00, 4'h0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; open_cmd = vecs[i].open; close_cmd = vecs[i].close;
            fault_clr = vecs[i].clr; pos = vecs[i].pos;
            tick();
            chk($sformatf("row%0d dir", i),   32'(dir),   32'(vecs[i].dir));
            chk($sformatf("row%0d busy", i),  32'(busy),  32'(vecs[i].busy));
            chk($sformatf("row%0d done", i),  32'(done),  32'(vecs[i].done));
            chk($sformatf("row%0d fault", i), 32'(fault), 32'(vecs[i].fault));
        end

        // Stall watchdog while opening.
        rst = 1'b1; open_cmd = 1'b0; close_cmd = 1'b0; fault_clr = 1'b0; pos = 2'b10;
        tick();
        rst = 1'b0; open_cmd = 1'b1;
        tick();
        open_cmd = 1'b0;
        chk("stall_start_dir", 32'(dir), 32'h1);
`ifdef GRILL_STALL_DETECT_EN
        for (int p = 0; p < 6; p++) begin
            sensor = 1'b1;
            tick(); tick();
            sensor = 1'b0;
            repeat (48) tick();
            chk($sformatf("stall_period%0d fault", p), 32'(fault), 32'h0);
        end
        sensor = 1'b1;
        tick(); tick();
        sensor = 1'b0;
        since = 2;
        seen  = 1'b0;
        while (!seen && since < 300) begin
            tick();
            since++;
            if (fault) seen = 1'b1;
        end
        chk("stall_fault_seen", 32'(seen), 32'h1);
        chk("stall_fault_window", 32'(since >= 100 && since <= 108), 32'h1);
        chk("stall_fault_dir", 32'(dir), 32'h0);
`else
        since = 0;
        seen  = 1'b0;
        repeat (300) begin
            tick();
            since++;
            if (fault) seen = 1'b1;
        end
        chk("nostall_fault", 32'(seen), 32'h0);
        chk("nostall_dir", 32'(dir), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
